// File: rtl/alu_pkg.sv
// Shared ALU definitions: default widths, FSM encoding and the flag bundle
// used by both the adder and the subtractor.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 16;
  localparam int unsigned ALU_SLICE = 4;
  localparam int unsigned ALU_NSTEP = ALU_WIDTH / ALU_SLICE;

  // Sequencer states for the slice-serial ALU units.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } alu_state_e;

  // Result flags, identical layout for add and subtract.
  typedef struct packed {
    logic sign;
    logic zero;
    logic borrow;
    logic overflow;
    logic parity;
  } alu_flags_t;

endpackage : alu_pkg

// File: rtl/alu_subtractor16_seq_slice.sv
// One slice of the serial subtractor: d = a + ~b + cin.
// A carry-out of 1 means "no borrow" out of this slice.
module sub4bit_slice #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] d,
  output logic         cout
);

  logic [W:0] sum;

  // Widen by one bit so the slice carry-out falls out of the add.
  always_comb begin
    sum  = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, cin};
    d    = sum[W-1:0];
    cout = sum[W];
  end

endmodule : sub4bit_slice

// File: rtl/alu_subtractor16_seq.sv
// Multi-cycle subtractor Z = X - Y. A single slice unit is reused, LSB
// slice first, with the borrow rippled through a carry flop between steps.
// Operand and result sides use valid/ready handshakes.
module alu_subtractor16_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH,  // must be a multiple of SLICE
  parameter int unsigned SLICE = ALU_SLICE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Z,
  output logic             sign,
  output logic             zero,
  output logic             borrow,
  output logic             overflow,
  output logic             parity
);

  localparam int unsigned NSTEP  = WIDTH / SLICE;
  localparam int unsigned STEP_W = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NSTEP - 1);

  alu_state_e        state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  x_q, x_d;
  logic [WIDTH-1:0]  y_q, y_d;
  logic [WIDTH-1:0]  z_q, z_d;
  alu_flags_t        flags_q, flags_d;

  logic [SLICE-1:0]  slice_a, slice_b, slice_d;
  logic              slice_cout;
  logic [WIDTH-1:0]  z_merged;

  // Pick the operand slices addressed by the current step.
  always_comb begin
    slice_a = x_q[step_q*SLICE +: SLICE];
    slice_b = y_q[step_q*SLICE +: SLICE];
  end

  sub4bit_slice #(
    .W (SLICE)
  ) u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .d    (slice_d),
    .cout (slice_cout)
  );

  // Result with this step's slice merged in; on the last step it is the full Z.
  always_comb begin
    z_merged = z_q;
    z_merged[step_q*SLICE +: SLICE] = slice_d;
  end

  // Next-state and datapath updates for the IDLE/RUN/DONE sequencer.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    state_d = state_q;
    step_d  = step_q;
    carry_d = carry_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    flags_d = flags_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d     = X;
          y_d     = Y;
          step_d  = '0;
          carry_d = 1'b1;  // +1 of the two's-complement negation of Y
          state_d = RUN;
        end
      end

      RUN: begin
        z_d     = z_merged;
        carry_d = slice_cout;
        step_d  = step_q + STEP_W'(1);
        if (step_q == LAST_STEP) begin
          flags_d.sign     = z_merged[WIDTH-1];
          flags_d.zero     = (z_merged == '0);
          flags_d.borrow   = ~slice_cout;
          flags_d.overflow = ( x_q[WIDTH-1] & ~y_q[WIDTH-1] & ~z_merged[WIDTH-1]) |
                             (~x_q[WIDTH-1] &  y_q[WIDTH-1] &  z_merged[WIDTH-1]);
          flags_d.parity   = ~^z_merged;
          state_d          = DONE;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Control, result and flag registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= IDLE;
      step_q  <= '0;
      carry_q <= 1'b0;
      z_q     <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      carry_q <= carry_d;
      z_q     <= z_d;
      flags_q <= flags_d;
    end
  end

  // Operand holding registers.
  always_ff @(posedge clk) begin
    // NOTE: no reset here on purpose; the operands are only read in RUN,
    // which is always entered through a load in IDLE.
    x_q <= x_d;
    y_q <= y_d;
  end

  // Handshake and result outputs straight from state.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    Z         = z_q;
    sign      = flags_q.sign;
    zero      = flags_q.zero;
    borrow    = flags_q.borrow;
    overflow  = flags_q.overflow;
    parity    = flags_q.parity;
  end

endmodule : alu_subtractor16_seq

// File: tb/tb_alu_subtractor16_seq.sv
// Scoreboard bench for alu_subtractor16_seq: the driver pushes the
// arithmetic reference result on each accepted operand pair, the monitor
// pops and compares whenever the DUT presents a result.
module tb_alu_subtractor16_seq;

  typedef struct {
    logic [15:0] z;
    logic [4:0]  flags;  // {sign, zero, borrow, overflow, parity}
    int          acc;    // clock edge at which the operands were accepted
    int          hold;   // cycles the monitor keeps out_ready low first
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x_in, y_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] z_out;
  logic        sign, zero, borrow, overflow, parity;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   last_consume = -100;
  exp_t sb_q[$];

  alu_subtractor16_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .X         (x_in),
    .Y         (y_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Z         (z_out),
    .sign      (sign),
    .zero      (zero),
    .borrow    (borrow),
    .overflow  (overflow),
    .parity    (parity)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference: plain integer subtraction and flag definitions.
  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input int hold);
    exp_t e;
    int ux, uy, sx, sy, sd;
    logic [15:0] z;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    sd = sx - sy;
    z  = 16'(ux - uy);
    e.z     = z;
    e.flags = {z[15], (z == 16'h0), (ux < uy), (sd > 32767 || sd < -32768),
               (($countones(z) % 2) == 0)};
    e.acc   = 0;
    e.hold  = hold;
    return e;
  endfunction

  // Called just after a negedge; returns just after the negedge following accept.
  task automatic issue(input logic [15:0] x, input logic [15:0] y, input int hold);
    exp_t e;
    bit   busy;
    bit   taken;
    busy     = (sb_q.size() != 0);
    taken    = 1'b0;
    x_in     = x;
    y_in     = y;
    in_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (in_ready) begin
        e     = model(x, y, hold);
        e.acc = cyc + 1;
        if (busy) check("accept_after_consume", e.acc, last_consume + 1);
        sb_q.push_back(e);
        taken = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!taken) check("accept_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
    x_in     = 16'($urandom);
    y_in     = 16'($urandom);
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (sb_q.size() == 0 && in_ready) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!done) check("drain_timeout", 0, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_z"}, z_out, 0);
    check({tag, "_flags"}, {sign, zero, borrow, overflow, parity}, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_in_ready"}, in_ready, 1);
  endtask

  // Monitor: compare the head of the scoreboard each cycle a result is shown.
  initial begin : monitor
    bit seen;
    int hold_left;
    exp_t e;
    seen      = 1'b0;
    hold_left = 0;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        out_ready = 1'b0;
      end else if (out_valid) begin
        if (sb_q.size() == 0) begin
          check("unexpected_valid", 1, 0);
          out_ready = 1'b1;
        end else begin
          e = sb_q[0];
          if (!seen) begin
            check("latency", cyc, e.acc + 4);
            seen      = 1'b1;
            hold_left = e.hold;
          end
          check("z", z_out, e.z);
          check("flags", {sign, zero, borrow, overflow, parity}, e.flags);
          check("in_ready_in_done", in_ready, 0);
          if (hold_left > 0) begin
            out_ready = 1'b0;
            hold_left--;
          end else begin
            out_ready = 1'($urandom_range(0, 1));
          end
          if (out_ready) begin
            void'(sb_q.pop_front());
            seen         = 1'b0;
            last_consume = cyc + 1;
          end
        end
      end else begin
        // out_ready must be ignored outside DONE, so toggle it freely here.
        out_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  // Driver: reset, directed cases, mid-RUN reset, then random traffic.
  initial begin : driver
    rst      = 1'b1;
    in_valid = 1'b0;
    x_in     = 16'h0;
    y_in     = 16'h0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    issue(16'h0005, 16'h0003, 0);
    issue(16'h0003, 16'h0005, 0);
    issue(16'h8000, 16'h0001, 0);
    issue(16'h1234, 16'h1234, 3);   // held 3 cycles in DONE
    issue(16'hFFFF, 16'h0F0F, 0);   // presented while the previous result waits
    issue(16'h0000, 16'h0001, 0);
    issue(16'h7FFF, 16'hFFFF, 0);
    wait_drain();

    // Reset on the second RUN cycle aborts the operation.
    issue(16'h00AA, 16'h0055, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    void'(sb_q.pop_back());
    check_reset_outputs("abort");
    issue(16'h0010, 16'h0001, 0);
    wait_drain();

    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(16'($urandom), 16'($urandom), int'($urandom_range(0, 2)));
    end
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_alu_subtractor16_seq
